// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle between an upstream producer and the dispatch block's output lanes.
// The master modport is the side that drives the inputs and the lane readies.
interface demux_dispatch_ctrl_if #(
  parameter int NUM_OUTPUT = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int DATA_WIDTH = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [SEL_WIDTH-1:0]             in_sel;
  logic                             in_bcast;
  logic                             mode_rr;
  logic [DATA_WIDTH*NUM_OUTPUT-1:0] out_data;
  logic [NUM_OUTPUT-1:0]            out_valid;
  logic [NUM_OUTPUT-1:0]            out_ready;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, mode_rr, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, mode_rr, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Single-word dispatcher: holds one accepted word and delivers it to a selected lane,
// the round-robin lane, or every lane in sequence (broadcast).
module demux_dispatch_ctrl #(
  parameter int NUM_OUTPUT = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int DATA_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_dispatch_ctrl_if.slave   bus,
  output logic                   busy,
  output logic                   err_sel,
  input  logic                   err_clr,
  output logic [15:0]            sent_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, BCAST} state_t;

  localparam logic [SEL_WIDTH:0]   NUM_OUT = (SEL_WIDTH+1)'(NUM_OUTPUT);
  localparam logic [SEL_WIDTH-1:0] LAST    = SEL_WIDTH'(NUM_OUTPUT-1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [SEL_WIDTH-1:0]  lane_q, lane_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  rr_used_q, rr_used_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  accept, drop, done;

  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] v);
    return (v == LAST) ? '0 : v + SEL_WIDTH'(1);
  endfunction

  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign err_sel      = err_q;
  assign sent_cnt     = cnt_q;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign drop   = accept && !bus.in_bcast && !bus.mode_rr && ({1'b0, bus.in_sel} >= NUM_OUT);

  // Outputs decode straight from the registered state so reset clears them at once.
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NUM_OUTPUT; i++) begin
        if (lane_q == SEL_WIDTH'(i)) begin
          bus.out_valid[i]                           = 1'b1;
          bus.out_data[i*DATA_WIDTH +: DATA_WIDTH]   = hold_q;
        end
      end
    end
  end

  // Only the target lane has a valid bit set, so foreign ready bits mask out here.
  assign done = |(bus.out_valid & bus.out_ready);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    lane_d    = lane_q;
    rr_ptr_d  = rr_ptr_q;
    rr_used_d = rr_used_q;
    cnt_d     = cnt_q;
    err_d     = drop ? 1'b1 : (err_clr ? 1'b0 : err_q);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_bcast) begin
            state_d = BCAST;
            lane_d  = '0;
            hold_d  = bus.in_data;
          end else if (bus.mode_rr) begin
            state_d   = SEND;
            lane_d    = rr_ptr_q;
            rr_used_d = 1'b1;
            hold_d    = bus.in_data;
          end else if (!drop) begin
            state_d   = SEND;
            lane_d    = bus.in_sel;
            rr_used_d = 1'b0;
            hold_d    = bus.in_data;
          end
        end
      end
      SEND: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 16'd1;
          if (rr_used_q) rr_ptr_d = wrap_inc(rr_ptr_q);
        end
      end
      BCAST: begin
        if (done) begin
          cnt_d = cnt_q + 16'd1;
          if (lane_q == LAST) state_d = IDLE;
          else                lane_d  = lane_q + SEL_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      lane_q    <= '0;
      rr_ptr_q  <= '0;
      rr_used_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      lane_q    <= lane_d;
      rr_ptr_q  <= rr_ptr_d;
      rr_used_q <= rr_used_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: an 8-lane instance against a delivery-queue model,
// plus a 6-lane instance exercising out-of-range select handling.
module tb_demux_dispatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_dispatch_ctrl_if #(.NUM_OUTPUT(8), .SEL_WIDTH(3), .DATA_WIDTH(4)) ifa();
  demux_dispatch_ctrl_if #(.NUM_OUTPUT(6), .SEL_WIDTH(3), .DATA_WIDTH(4)) ifb();

  logic        busy_a, err_a, clr_a;
  logic [15:0] cnt_a;
  logic        busy_b, err_b, clr_b;
  logic [15:0] cnt_b;

  demux_dispatch_ctrl #(.NUM_OUTPUT(8), .SEL_WIDTH(3), .DATA_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .busy(busy_a), .err_sel(err_a), .err_clr(clr_a), .sent_cnt(cnt_a)
  );

  demux_dispatch_ctrl #(.NUM_OUTPUT(6), .SEL_WIDTH(3), .DATA_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .busy(busy_b), .err_sel(err_b), .err_clr(clr_b), .sent_cnt(cnt_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: pending lane deliveries in order; rr pointer advanced at acceptance.
  typedef struct {int lane; logic [3:0] data;} dlv_t;
  dlv_t q[$];
  int   m_rr   = 0;
  int   m_sent = 0;
  bit   m_err  = 0;

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_sent = 0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0]  ev;
    logic [31:0] ed;
    ev = '0; ed = '0;
    if (q.size() > 0) begin
      ev[q[0].lane]          = 1'b1;
      ed[q[0].lane*4 +: 4]   = q[0].data;
    end
    check({tag, ".out_valid"}, 64'(ifa.out_valid), 64'(ev));
    check({tag, ".out_data"},  64'(ifa.out_data),  64'(ed));
    check({tag, ".in_ready"},  64'(ifa.in_ready),  64'(q.size() == 0));
    check({tag, ".busy"},      64'(busy_a),        64'(q.size() != 0));
    check({tag, ".err_sel"},   64'(err_a),         64'(m_err));
    check({tag, ".sent_cnt"},  64'(cnt_a),         64'(m_sent & 32'hFFFF));
  endtask

  // Called just after a falling edge: check, drive, advance the model, cross one rising edge.
  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic [2:0] s,
                      input logic b, input logic rr, input logic [7:0] ordy, input logic ec);
    bit was_idle;
    check_outputs(tag);
    ifa.in_valid = v; ifa.in_data = d; ifa.in_sel = s;
    ifa.in_bcast = b; ifa.mode_rr = rr; ifa.out_ready = ordy; clr_a = ec;
    was_idle = (q.size() == 0);
    if (!was_idle && ordy[q[0].lane]) begin
      void'(q.pop_front());
      m_sent++;
    end
    if (was_idle && v) begin
      if (b) begin
        for (int k = 0; k < 8; k++) q.push_back('{k, d});
      end else if (rr) begin
        q.push_back('{m_rr, d});
        m_rr = (m_rr + 1) % 8;
      end else begin
        q.push_back('{int'(s), d});
      end
    end
    if (ec) m_err = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit %0t", $time, 2_000_000);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.in_valid = 0; ifa.in_data = 0; ifa.in_sel = 0; ifa.in_bcast = 0; ifa.mode_rr = 0;
    ifa.out_ready = '0; clr_a = 0;
    ifb.in_valid = 0; ifb.in_data = 0; ifb.in_sel = 0; ifb.in_bcast = 0; ifb.mode_rr = 0;
    ifb.out_ready = '0; clr_b = 0;
    model_reset();

    // Reset state, with a word offered that must not be taken while rst_n is low.
    ifa.in_valid = 1; ifa.in_data = 4'h7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    ifa.in_valid = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed select to lane 5.
    step("sel5_acc", 1, 4'hA, 3'd5, 0, 0, 8'hFF, 0);
    check("sel5.out_valid", 64'(ifa.out_valid), 64'h20);
    check("sel5.lane5",     64'(ifa.out_data[23:20]), 64'hA);
    step("sel5_done", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    check("sel5.sent_cnt", 64'(cnt_a), 64'd1);
    check("sel5.in_ready", 64'(ifa.in_ready), 64'd1);

    // Round-robin: 9 words wrap back to lane 0.
    for (int k = 1; k <= 9; k++) begin
      step("rr_acc", 1, 4'(k), 3'd6, 0, 1, 8'hFF, 0);
      if (k == 9) check("rr.wrap_lane0", 64'(ifa.out_valid), 64'h01);
      step("rr_done", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    end
    check("rr.sent_cnt", 64'(cnt_a), 64'd10);

    // Broadcast with lane 2 stalled for four cycles.
    step("bc_acc", 1, 4'h3, 3'd0, 1, 0, 8'hFF, 0);
    step("bc_l0", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    step("bc_l1", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    for (int k = 0; k < 4; k++) begin
      check("bc.stall_valid", 64'(ifa.out_valid), 64'h04);
      check("bc.stall_data",  64'(ifa.out_data),  64'h0000_0300);
      step("bc_stall", 0, 4'h0, 3'd0, 0, 0, 8'hFB, 0);
    end
    for (int k = 2; k < 8; k++) step("bc_rest", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    check("bc.sent_cnt", 64'(cnt_a), 64'd18);
    check("bc.idle",     64'(busy_a), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic       v, b, rr, ec;
      logic [7:0] ordy;
      v    = ($urandom_range(0, 9) < 7);
      b    = ($urandom_range(0, 7) == 0);
      rr   = ($urandom_range(0, 2) == 0);
      ec   = ($urandom_range(0, 7) == 0);
      ordy = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      step("rand", v, 4'($urandom), 3'($urandom), b, rr, ordy, ec);
    end
    while (q.size() > 0) step("drain", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);

    // Make rr_ptr nonzero, then reset while a SEND waits.
    step("pre_rst_rr", 1, 4'h1, 3'd0, 0, 1, 8'hFF, 0);
    step("pre_rst_rr2", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    step("rst_acc", 1, 4'hC, 3'd3, 0, 0, 8'h00, 0);
    step("rst_wait", 0, 4'h0, 3'd0, 0, 0, 8'h00, 0);
    check("rst.pre_valid", 64'(ifa.out_valid), 64'h08);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid", 64'(ifa.out_valid), 64'h0);
    check("rst.out_data",  64'(ifa.out_data),  64'h0);
    check("rst.sent_cnt",  64'(cnt_a), 64'd0);
    check("rst.in_ready",  64'(ifa.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_rr", 1, 4'h5, 3'd4, 0, 1, 8'hFF, 0);
    check("post_rst.rr_lane0", 64'(ifa.out_valid), 64'h01);
    step("post_rst_done", 0, 4'h0, 3'd0, 0, 0, 8'hFF, 0);
    check_outputs("post_rst_idle");

    // Six-lane instance: out-of-range select handling.
    ifb.out_ready = 6'h3F;
    ifb.in_valid = 1; ifb.in_sel = 3'd7; ifb.in_data = 4'h9;
    @(posedge clk); @(negedge clk);
    check("b.oor_valid", 64'(ifb.out_valid), 64'h0);
    check("b.oor_err",   64'(err_b),         64'd1);
    check("b.oor_ready", 64'(ifb.in_ready),  64'd1);
    ifb.in_sel = 3'd6; clr_b = 1;
    @(posedge clk); @(negedge clk);
    check("b.set_wins",  64'(err_b),         64'd1);
    check("b.oor6_valid", 64'(ifb.out_valid), 64'h0);
    ifb.in_valid = 0;
    @(posedge clk); @(negedge clk);
    check("b.clr",       64'(err_b),         64'd0);
    clr_b = 0; ifb.in_valid = 1; ifb.in_sel = 3'd5; ifb.in_data = 4'hA;
    @(posedge clk); @(negedge clk);
    ifb.in_valid = 0;
    check("b.sel5_valid", 64'(ifb.out_valid), 64'h20);
    check("b.sel5_data",  64'(ifb.out_data),  64'hA0_0000);
    @(posedge clk); @(negedge clk);
    check("b.sent_cnt",  64'(cnt_b),         64'd1);
    check("b.in_ready",  64'(ifb.in_ready),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter NUM_OUTPUT, default 8, number of output lanes (2..2^SEL_WIDTH).
REQ-002 Parameter SEL_WIDTH, default 3, width of the destination select.
REQ-003 Parameter DATA_WIDTH, default 4, width of one data word.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  upstream word valid.
REQ-008 in_ready  out  1  block can accept a word this cycle.
REQ-009 in_data  in  DATA_WIDTH  word to deliver.
REQ-010 in_sel  in  SEL_WIDTH  destination lane; ignored in RR or broadcast.
REQ-011 in_bcast  in  1  deliver the word to every lane in turn.
REQ-012 mode_rr  in  1  ignore in_sel; use the internal round-robin pointer.
REQ-013 out_data  out  DATA_WIDTH*NUM_OUTPUT  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 out_valid  out  NUM_OUTPUT  per-lane valid; at most one bit set.
REQ-015 out_ready  in  NUM_OUTPUT  per-lane downstream ready.
REQ-016 busy  out  1  a word is held (state is not IDLE).
REQ-017 err_sel  out  1  sticky flag: an out-of-range in_sel was dropped.
REQ-018 err_clr  in  1  clears err_sel.
REQ-019 sent_cnt  out  16  count of completed lane handshakes; wraps modulo 2^16.

Function
REQ-020 The FSM SHALL have three states: IDLE, SEND and BCAST.
REQ-021 in_ready SHALL equal (state==IDLE); there is no combinational bypass from out_ready.
REQ-022 Accept: when in_valid && in_ready at an edge, the block SHALL latch in_data into a hold register.
REQ-023 Accept target: in_bcast=1 -> BCAST with lane index 0; else mode_rr=1 -> SEND to rr_ptr; else SEND to in_sel.
REQ-024 in_bcast, mode_rr and in_sel SHALL be sampled only at acceptance; later changes have no effect on the held word.
REQ-025 Out-of-range select: in non-RR, non-broadcast mode with in_sel >= NUM_OUTPUT, the word SHALL be dropped, err_sel set, and the state SHALL stay IDLE.
REQ-026 In SEND and BCAST, out_valid SHALL be one-hot at the current target lane.
REQ-027 In SEND and BCAST, out_data SHALL carry the held word on the target lane; all other lanes SHALL be zero.
REQ-028 In IDLE, out_valid and out_data SHALL be all zero.
REQ-029 Latency: out_valid SHALL assert in the cycle after acceptance.
REQ-030 out_valid and out_data SHALL stay stable until out_ready of the target lane is high at an edge (the completion edge).
REQ-031 Ready bits of non-target lanes SHALL be ignored.
REQ-032 SEND completion: the state SHALL return to IDLE, sent_cnt SHALL increment, and rr_ptr SHALL advance if the word was accepted with mode_rr=1.
REQ-033 rr_ptr SHALL wrap from NUM_OUTPUT-1 to 0.
REQ-034 BCAST completion on lane k<NUM_OUTPUT-1: the lane index SHALL advance to k+1 and sent_cnt SHALL increment.
REQ-035 BCAST completion on lane NUM_OUTPUT-1: the state SHALL return to IDLE and sent_cnt SHALL increment.
REQ-036 BCAST SHALL NOT change rr_ptr.
REQ-037 Peak throughput SHALL be one word per two cycles for SEND and NUM_OUTPUT+1 cycles per BCAST word when ready is held high.
REQ-038 If err_clr and a new out-of-range drop occur in the same cycle, err_sel SHALL be set (set wins).
REQ-039 busy SHALL be high exactly when the state is not IDLE.

Reset
REQ-040 On rst_n low, asynchronously: state=IDLE; hold register, rr_ptr, lane index, sent_cnt and err_sel=0; out_valid=0; out_data=0.
REQ-041 With rst_n low, in_ready SHALL be 1 (IDLE); no word SHALL be accepted until the first rising edge after rst_n deasserts.
REQ-042 Reset mid-SEND or mid-BCAST SHALL discard the held word with no further out_valid.

Verification
REQ-043 in_sel=5, in_data=0xA, out_ready=all ones -> out_valid=0x20 one cycle later, lane 5 data=0xA, other lanes 0, sent_cnt=1, in_ready high the next cycle.
REQ-044 mode_rr=1, 9 words 0x1..0x9, out_ready all ones -> lanes 0..7 then lane 0 again (wrap), sent_cnt=9.
REQ-045 in_bcast=1, data=0x3, out_ready[2] held low for 4 cycles -> lanes 0,1 served, then valid held on lane 2 with data stable for 4 cycles, then lanes 3..7 served, sent_cnt=8, back to IDLE.
REQ-046 NUM_OUTPUT=6, in_sel=7 -> no out_valid, err_sel=1, in_ready stays high; err_clr with a simultaneous in_sel=6 keeps err_sel=1.
REQ-047 rst_n pulsed low while SEND waits with out_ready=0 -> out_valid=0 immediately, sent_cnt=0, rr_ptr=0, a new word is accepted after release.
